// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Turns hazard-detector stall requests, EX branch flushes and data-memory busy
// into per-stage write enables, IF/ID flush and ID/EX bubble controls for a
// 5-stage pipeline. Control outputs are combinational from the current state
// and inputs, so each response takes effect in the same cycle as its request.
// The module also keeps saturating counters of stall, freeze and flush events.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   stall_req         load-use hazard request (level)
//   flush_req         taken branch/jump resolved in EX (pulse)
//   mem_busy          data memory not ready: freeze every stage
//   cnt_clr           synchronous clear of the performance counters
//   pc_we, ifid_we, idex_we, exmem_we   stage register write enables
//   ifid_flush        zero the IF/ID contents
//   idex_bubble       load a NOP into ID/EX
//   stall_active      PC held by a stall or freeze (not by a flush)
//   stall_cnt         cycles spent bubbling ID/EX for a stall
//   freeze_cnt        cycles frozen by mem_busy
//   flush_cnt         accepted flushes
module pipeline_stall_ctrl #(
    parameter int STALL_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             flush_req,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int REM_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    state_t           ret_state_q, ret_state_d;
    state_t           eff_state;
    logic [REM_W-1:0] rem_q, rem_d;

    // Increment strobes, index 0 = stall, 1 = freeze, 2 = flush.
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    always_comb begin
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        rem_d        = rem_q;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        stall_active = 1'b0;
        cnt_inc      = 3'b000;
        // Leaving a freeze resumes exactly as the state that was frozen.
        eff_state    = (state_q == FREEZE) ? ret_state_q : state_q;

        if (reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            state_d     = RUN;
            ret_state_d = RUN;
            rem_d       = '0;
        end else if (mem_busy) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            stall_active = 1'b1;
            cnt_inc[1]   = 1'b1;
            // Only remember the state on entry; rem is left untouched so a
            // frozen stall finishes its remaining cycles afterwards.
            if (state_q != FREEZE) begin
                ret_state_d = state_q;
            end
            state_d = FREEZE;
        end else if (flush_req) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            cnt_inc[2]  = 1'b1;
            state_d     = RUN;
            rem_d       = '0;
        end else if (eff_state == STALL) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
            cnt_inc[0]   = 1'b1;
            if (rem_q <= REM_W'(1)) begin
                state_d = RUN;
                rem_d   = '0;
            end else begin
                state_d = STALL;
                rem_d   = rem_q - REM_W'(1);
            end
        end else if (stall_req) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
            cnt_inc[0]   = 1'b1;
            if (STALL_CYCLES > 1) begin
                state_d = STALL;
                rem_d   = REM_W'(STALL_CYCLES - 1);
            end else begin
                state_d = RUN;
                rem_d   = '0;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        ret_state_q <= ret_state_d;
        rem_q       <= rem_d;
    end

    // Saturating counters; a clear wins over a same-cycle increment.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        always_comb begin
            cnt_d[gi] = cnt_q[gi];
            if (reset || cnt_clr) begin
                cnt_d[gi] = '0;
            end else if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
                cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            cnt_q[gi] <= cnt_d[gi];
        end
    end

    assign stall_cnt  = cnt_q[0];
    assign freeze_cnt = cnt_q[1];
    assign flush_cnt  = cnt_q[2];

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl. Drivers push the hand-computed
// expected outputs for every cycle they drive; monitors pop and compare on the
// falling edge. A second instance with 4-bit counters exercises saturation.
module tb_pipeline_stall_ctrl;

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, stall_active}
    localparam logic [6:0] V_RUN = 7'b1101010;
    localparam logic [6:0] V_STL = 7'b0001111;
    localparam logic [6:0] V_FLU = 7'b1111110;
    localparam logic [6:0] V_FRZ = 7'b0000001;
    localparam logic [6:0] V_RST = 7'b0000000;

    typedef struct {
        logic [6:0] vec;
        bit         chk;
        int         sc;
        int         fz;
        int         fl;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    exp_t q_main[$];
    exp_t q_sat[$];
    bit   sat_done = 1'b0;

    // ---------------- main instance ----------------
    logic        reset = 1'b1, stall_req = 1'b0, flush_req = 1'b0, mem_busy = 1'b0, cnt_clr = 1'b0;
    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, stall_active;
    logic [15:0] stall_cnt, freeze_cnt, flush_cnt;

    pipeline_stall_ctrl #(.STALL_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall_req(stall_req), .flush_req(flush_req),
        .mem_busy(mem_busy), .cnt_clr(cnt_clr), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_bubble(idex_bubble),
        .exmem_we(exmem_we), .stall_active(stall_active), .stall_cnt(stall_cnt),
        .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
    );

    // ---------------- saturation instance ----------------
    logic        s_reset = 1'b1, s_stall = 1'b0, s_clr = 1'b0;
    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_bubble, s_exmem_we, s_stall_active;
    logic [3:0]  s_stall_cnt, s_freeze_cnt, s_flush_cnt;

    pipeline_stall_ctrl #(.STALL_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(s_reset), .stall_req(s_stall), .flush_req(1'b0),
        .mem_busy(1'b0), .cnt_clr(s_clr), .pc_we(s_pc_we), .ifid_we(s_ifid_we),
        .ifid_flush(s_ifid_flush), .idex_we(s_idex_we), .idex_bubble(s_idex_bubble),
        .exmem_we(s_exmem_we), .stall_active(s_stall_active), .stall_cnt(s_stall_cnt),
        .freeze_cnt(s_freeze_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic drive(input logic r, input logic s, input logic f, input logic m,
                         input logic c, input logic [6:0] vec, input bit chk,
                         input int sc, input int fz, input int fl, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; stall_req = s; flush_req = f; mem_busy = m; cnt_clr = c;
        e.vec = vec; e.chk = chk; e.sc = sc; e.fz = fz; e.fl = fl; e.name = nm;
        q_main.push_back(e);
    endtask

    task automatic drive_sat(input logic r, input logic s, input logic c,
                             input logic [6:0] vec, input bit chk, input int sc,
                             input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        s_reset = r; s_stall = s; s_clr = c;
        e.vec = vec; e.chk = chk; e.sc = sc; e.fz = 0; e.fl = 0; e.name = nm;
        q_sat.push_back(e);
    endtask

    // Main monitor
    initial begin
        exp_t        e;
        logic [6:0]  got;
        forever begin
            @(negedge clk);
            if (q_main.size() > 0) begin
                e   = q_main.pop_front();
                got = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, stall_active};
                total_cnt++;
                if (got === e.vec) pass_cnt++;
                else $display("FAIL %s ctrl: got %b expected %b", e.name, got, e.vec);
                if (e.chk) begin
                    total_cnt++;
                    if ({stall_cnt, freeze_cnt, flush_cnt} === {16'(e.sc), 16'(e.fz), 16'(e.fl)})
                        pass_cnt++;
                    else
                        $display("FAIL %s cnt: got stall=%0d freeze=%0d flush=%0d expected %0d/%0d/%0d",
                                 e.name, stall_cnt, freeze_cnt, flush_cnt, e.sc, e.fz, e.fl);
                end
                $display("main %-10s vec=%b stall=%0d freeze=%0d flush=%0d",
                         e.name, got, stall_cnt, freeze_cnt, flush_cnt);
            end
        end
    end

    // Saturation monitor
    initial begin
        exp_t        e;
        logic [6:0]  got;
        forever begin
            @(negedge clk);
            if (q_sat.size() > 0) begin
                e   = q_sat.pop_front();
                got = {s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_bubble, s_exmem_we, s_stall_active};
                total_cnt++;
                if (got === e.vec) pass_cnt++;
                else $display("FAIL %s ctrl: got %b expected %b", e.name, got, e.vec);
                if (e.chk) begin
                    total_cnt++;
                    if ({s_stall_cnt, s_freeze_cnt, s_flush_cnt} === {4'(e.sc), 4'd0, 4'd0})
                        pass_cnt++;
                    else
                        $display("FAIL %s cnt: got stall=%0d freeze=%0d flush=%0d expected %0d/0/0",
                                 e.name, s_stall_cnt, s_freeze_cnt, s_flush_cnt, e.sc);
                end
                $display("sat  %-10s vec=%b stall=%0d", e.name, got, s_stall_cnt);
            end
        end
    end

    // Saturation stimulus: hold stall_req 20 cycles with 4-bit counters.
    initial begin
        drive_sat(1, 0, 0, V_RST, 0, 0, "s_rst0");
        drive_sat(1, 0, 0, V_RST, 1, 0, "s_rst1");
        for (int k = 0; k < 20; k++)
            drive_sat(0, 1, 0, V_STL, 1, (k < 15) ? k : 15, "s_hold");
        drive_sat(0, 0, 1, V_RUN, 1, 15, "s_clr");
        drive_sat(0, 0, 0, V_RUN, 1, 0, "s_after");
        drive_sat(0, 0, 0, V_RUN, 1, 0, "s_idle");
        sat_done = 1'b1;
    end

    // Main stimulus. Args: reset, stall, flush, mem_busy, cnt_clr, vec, chk, stall/freeze/flush counts
    initial begin
        int guard;
        drive(1, 0, 0, 0, 0, V_RST, 0, 0, 0, 0, "rst0");
        drive(1, 0, 0, 0, 0, V_RST, 1, 0, 0, 0, "rst1");
        drive(0, 0, 0, 0, 0, V_RUN, 1, 0, 0, 0, "idle");
        // single-cycle pulse -> two bubble cycles
        drive(0, 1, 0, 0, 0, V_STL, 1, 0, 0, 0, "pulse1");
        drive(0, 0, 0, 0, 0, V_STL, 1, 1, 0, 0, "pulse2");
        drive(0, 0, 0, 0, 1, V_RUN, 1, 2, 0, 0, "pulse_end");
        // held 4 cycles -> 4 consecutive stall cycles
        drive(0, 1, 0, 0, 0, V_STL, 1, 0, 0, 0, "hold1");
        drive(0, 1, 0, 0, 0, V_STL, 1, 1, 0, 0, "hold2");
        drive(0, 1, 0, 0, 0, V_STL, 1, 2, 0, 0, "hold3");
        drive(0, 1, 0, 0, 0, V_STL, 1, 3, 0, 0, "hold4");
        drive(0, 0, 0, 0, 1, V_RUN, 1, 4, 0, 0, "hold_end");
        // flush in second stall cycle
        drive(0, 1, 0, 0, 0, V_STL, 1, 0, 0, 0, "fl_stl");
        drive(0, 0, 1, 0, 0, V_FLU, 1, 1, 0, 0, "fl_flush");
        drive(0, 0, 0, 0, 1, V_RUN, 1, 1, 0, 1, "fl_end");
        // freeze 3 cycles during stall cycle 2; stall/flush ignored while frozen
        drive(0, 1, 0, 0, 0, V_STL, 1, 0, 0, 0, "fz_stl");
        drive(0, 0, 0, 1, 0, V_FRZ, 1, 1, 0, 0, "fz1");
        drive(0, 1, 1, 1, 0, V_FRZ, 1, 1, 1, 0, "fz2_ign");
        drive(0, 0, 0, 1, 0, V_FRZ, 1, 1, 2, 0, "fz3");
        drive(0, 0, 0, 0, 0, V_STL, 1, 1, 3, 0, "fz_resume");
        drive(0, 0, 0, 0, 1, V_RUN, 1, 2, 3, 0, "fz_end");
        // freeze from RUN, flush accepted on the first unfrozen cycle
        drive(0, 0, 0, 1, 0, V_FRZ, 1, 0, 0, 0, "fzr");
        drive(0, 0, 1, 0, 0, V_FLU, 1, 0, 1, 0, "fzr_flush");
        // cnt_clr beats same-cycle increment
        drive(0, 1, 0, 0, 1, V_STL, 1, 0, 1, 1, "clr_inc");
        drive(0, 0, 0, 0, 0, V_STL, 1, 0, 0, 0, "clr_stl2");
        drive(0, 0, 0, 0, 0, V_RUN, 1, 1, 0, 0, "clr_end");
        // reset mid-stall
        drive(0, 1, 0, 0, 0, V_STL, 1, 1, 0, 0, "rs_stl");
        drive(1, 0, 0, 0, 0, V_RST, 1, 2, 0, 0, "rs_reset");
        drive(0, 0, 0, 0, 0, V_RUN, 1, 0, 0, 0, "rs_run");
        // flush wins over simultaneous stall_req
        drive(0, 1, 1, 0, 0, V_FLU, 1, 0, 0, 0, "fl_pri");
        drive(0, 0, 0, 0, 0, V_RUN, 1, 0, 0, 1, "fl_pri_end");

        guard = 0;
        while (!sat_done && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        if (!sat_done || q_main.size() != 0 || q_sat.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: sat_done=%0d main_left=%0d sat_left=%0d required 1/0/0",
                     sat_done, q_main.size(), q_sat.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
